clause_dispatch_ctrl: RTL

- Sequences one clause-distribution run: accepts a stream of clauses from clause memory and pushes each one to exactly one of ENGINE_CNT BCP engine input queues.
- Selects the target engine round-robin among engines whose queue is not full.
- Sits between the clause fetch stream and the per-engine clause FIFOs.
- Reports run progress, and pulses done when the programmed clause count has been delivered.

---
 rtl/clause_dispatch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/clause_dispatch_ctrl.sv
// Clause dispatch controller: takes clauses from the fetch stream into a one-entry
// holding register and pushes each to a non-full engine queue, round-robin.
// Optional abort input is compiled in when DISPATCH_ABORT_EN is defined.
module clause_dispatch_ctrl #(
  parameter int ENGINE_CNT   = 4,
  parameter int CLAUSE_WIDTH = 4,
  parameter int ELEMENT_CNT  = 1024,
  parameter int CNT_W        = 16,
  localparam int LIT_W       = $clog2(ELEMENT_CNT) + 1,
  localparam int CLAUSE_BITS = CLAUSE_WIDTH * LIT_W,
  localparam int PTR_W       = (ENGINE_CNT > 1) ? $clog2(ENGINE_CNT) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef DISPATCH_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_clauses,
  input  logic                   clause_valid,
  input  logic [CLAUSE_BITS-1:0] clause_in,
  output logic                   clause_ready,
  input  logic [ENGINE_CNT-1:0]  full_in,
  output logic [ENGINE_CNT-1:0]  push_out,
  output logic [CLAUSE_BITS-1:0] clause_out,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       dispatched_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [CLAUSE_BITS-1:0] hold_clause_q, hold_clause_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       accepted_cnt_q, accepted_cnt_d;
  logic [CNT_W-1:0]       dispatched_cnt_q, dispatched_cnt_d;
  logic [CNT_W-1:0]       num_clauses_q, num_clauses_d;

  logic                   winner_found;
  logic [PTR_W-1:0]       winner_idx;
  logic                   push_any;
  logic                   accept;
  logic                   abort_act;

`ifdef DISPATCH_ABORT_EN
  assign abort_act = abort && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // First non-full engine scanning upward from rr_ptr, wrapping around.
  always_comb begin
    int idx;
    winner_found = 1'b0;
    winner_idx   = '0;
    idx          = 0;
    for (int k = 0; k < ENGINE_CNT; k++) begin
      idx = (int'(rr_ptr_q) + k) % ENGINE_CNT;
      if (!winner_found && !full_in[idx]) begin
        winner_found = 1'b1;
        winner_idx   = PTR_W'(idx);
      end
    end
  end

  assign push_any     = (state_q == RUN) && hold_valid_q && winner_found && !abort_act;
  assign clause_ready = (state_q == RUN) && (!hold_valid_q || push_any) &&
                        (accepted_cnt_q < num_clauses_q) && !abort_act;
  assign accept       = clause_valid && clause_ready;

  for (genvar gi = 0; gi < ENGINE_CNT; gi++) begin : g_push
    assign push_out[gi] = push_any && (winner_idx == PTR_W'(gi));
  end

  assign clause_out     = hold_clause_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign dispatched_cnt = dispatched_cnt_q;

  always_comb begin
    state_d          = state_q;
    hold_valid_d     = hold_valid_q;
    hold_clause_d    = hold_clause_q;
    rr_ptr_d         = rr_ptr_q;
    accepted_cnt_d   = accepted_cnt_q;
    dispatched_cnt_d = dispatched_cnt_q;
    num_clauses_d    = num_clauses_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_clauses_d    = num_clauses;
          accepted_cnt_d   = '0;
          dispatched_cnt_d = '0;
          hold_valid_d     = 1'b0;
          state_d          = (num_clauses == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push_any) begin
          rr_ptr_d         = (winner_idx == PTR_W'(ENGINE_CNT - 1)) ? '0 : winner_idx + PTR_W'(1);
          dispatched_cnt_d = dispatched_cnt_q + CNT_W'(1);
          hold_valid_d     = 1'b0;
          if (dispatched_cnt_q + CNT_W'(1) == num_clauses_q) begin
            state_d = DONE;
          end
        end
        // A same-cycle accept refills the slot just vacated by the push.
        if (accept) begin
          hold_valid_d   = 1'b1;
          hold_clause_d  = clause_in;
          accepted_cnt_d = accepted_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_act) begin
      state_d      = IDLE;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      hold_valid_q     <= 1'b0;
      hold_clause_q    <= '0;
      rr_ptr_q         <= '0;
      accepted_cnt_q   <= '0;
      dispatched_cnt_q <= '0;
      num_clauses_q    <= '0;
    end else begin
      state_q          <= state_d;
      hold_valid_q     <= hold_valid_d;
      hold_clause_q    <= hold_clause_d;
      rr_ptr_q         <= rr_ptr_d;
      accepted_cnt_q   <= accepted_cnt_d;
      dispatched_cnt_q <= dispatched_cnt_d;
      num_clauses_q    <= num_clauses_d;
    end
  end

endmodule
